// File: rtl/des_pkg.sv
// DES key-schedule shared definitions: permutation tables,
// shift schedule, widths and the generator state enum.
package des_pkg;

  localparam int SUBKEY_W = 48;
  localparam int KEYEX_W  = 768;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam logic [1:0] SHIFTS [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  // Tables use DES numbering: bit 1 is the MSB of the vector.
  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] r;
    r = '0;
    for (int i = 0; i < 56; i++) begin
      r[55-i] = k[64-PC1_T[i]];
    end
    return r;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < 48; i++) begin
      r[47-i] = cd[56-PC2_T[i]];
    end
    return r;
  endfunction

endpackage

// File: rtl/des_key_expand_if.sv
// Host-side bundle of the key expander: key load strobe in,
// expanded-key bus and status flags out.
interface des_key_expand_if;
  import des_pkg::*;

  logic [63:0]        i_key;
  logic               i_key_en;
  logic [KEYEX_W-1:0] o_keyex;
  logic               o_key_ok;
  logic               o_busy;

  modport master (
    output i_key,
    output i_key_en,
    input  o_keyex,
    input  o_key_ok,
    input  o_busy
  );

  modport slave (
    input  i_key,
    input  i_key_en,
    output o_keyex,
    output o_key_ok,
    output o_busy
  );

endinterface

// File: rtl/des_key_round.sv
// One key-schedule round: rotate C and D left, then PC-2.
module des_key_round
  import des_pkg::*;
(
  input  logic [27:0]         c_i,
  input  logic [27:0]         d_i,
  input  logic [1:0]          shift_i,
  output logic [27:0]         c_o,
  output logic [27:0]         d_o,
  output logic [SUBKEY_W-1:0] subkey_o
);

  always_comb begin
    c_o = c_i;
    d_o = d_i;
    unique case (1'b1)
      (shift_i == 2'd1): begin
        c_o = {c_i[26:0], c_i[27]};
        d_o = {d_i[26:0], d_i[27]};
      end
      default: begin
        c_o = {c_i[25:0], c_i[27:26]};
        d_o = {d_i[25:0], d_i[27:26]};
      end
    endcase
  end

  assign subkey_o = pc2({c_o, d_o});

endmodule

// File: rtl/des_key_expand.sv
// Iterative DES key schedule: PC-1 on load, then one subkey
// slot per clock for sixteen clocks.
module des_key_expand
  import des_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst,
  des_key_expand_if.slave bus
);

  state_t             state_q, state_d;
  logic [55:0]        cd_q, cd_d;
  logic [4:0]         round_q, round_d;
  logic [KEYEX_W-1:0] keyex_q, keyex_d;

  logic [27:0]         c_nx;
  logic [27:0]         d_nx;
  logic [SUBKEY_W-1:0] sub;
  logic [3:0]          slot;
  logic [3:0]          sidx;

  // K1 lives in the top slot, K16 in the bottom one.
  assign slot = 4'(5'd16 - round_q);
  assign sidx = 4'(round_q - 5'd1);

  des_key_round u_round (
    .c_i      (cd_q[55:28]),
    .d_i      (cd_q[27:0]),
    .shift_i  (SHIFTS[sidx]),
    .c_o      (c_nx),
    .d_o      (d_nx),
    .subkey_o (sub)
  );

  always_comb begin
    state_d = state_q;
    cd_d    = cd_q;
    round_d = round_q;
    keyex_d = keyex_q;
    if (bus.i_key_en) begin
      cd_d    = pc1(bus.i_key);
      round_d = 5'd1;
      state_d = BUSY;
    end else begin
      unique case (state_q)
        BUSY: begin
          cd_d = {c_nx, d_nx};
          keyex_d[int'(slot)*SUBKEY_W +: SUBKEY_W] = sub;
          if (round_q == 5'd16) begin
            round_d = 5'd0;
            state_d = DONE;
          end else begin
            round_d = round_q + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      cd_q    <= '0;
      round_q <= '0;
      keyex_q <= '0;
    end else begin
      state_q <= state_d;
      cd_q    <= cd_d;
      round_q <= round_d;
      keyex_q <= keyex_d;
    end
  end

  assign bus.o_keyex  = keyex_q;
  assign bus.o_busy   = (state_q == BUSY);
  assign bus.o_key_ok = (state_q == DONE);

endmodule
